// File: rtl/fetch_pkg.sv
// Shared types, line geometry and PC helpers for the fetch line buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    SERVE = 2'd3
  } fetch_state_t;

  localparam int PC_WIDTH       = 64;
  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 16;
  localparam int LINE_OFF_BITS  = 6;
  localparam int WORD_IDX_BITS  = 4;

  function automatic logic [PC_WIDTH-1:0] line_addr(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
  endfunction

  function automatic logic [WORD_IDX_BITS-1:0] word_idx(input logic [PC_WIDTH-1:0] pc);
    return pc[LINE_OFF_BITS-1:2];
  endfunction

endpackage

// File: rtl/fetch_word_select.sv
// Combinational word mux: picks one instruction out of a buffered cache line.
module fetch_word_select
  import fetch_pkg::*;
#(
  parameter int LINE_BITS   = 512,
  parameter int INSTR_WIDTH = 32
) (
  input  logic [LINE_BITS-1:0]     line_i,
  input  logic [WORD_IDX_BITS-1:0] idx_i,
  output logic [INSTR_WIDTH-1:0]   instr_o
);

  localparam int N_WORDS = LINE_BITS / INSTR_WIDTH;

  logic [INSTR_WIDTH-1:0] words [N_WORDS];

  for (genvar g = 0; g < N_WORDS; g++) begin : g_words
    assign words[g] = line_i[g*INSTR_WIDTH +: INSTR_WIDTH];
  end

  assign instr_o = words[idx_i];

endmodule

// File: rtl/fetch_line_buffer.sv
// One-line instruction buffer between memory_fetch and decode: issues words in
// PC order, refills on line exhaustion, and retargets on redirects.
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int LINE_BITS   = 512,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   entry_valid,
  input  logic [ADDR_WIDTH-1:0]  entry_pc,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [LINE_BITS-1:0]   mem_data,
  input  logic                   mem_data_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);

  localparam int TAG_BITS = ADDR_WIDTH - LINE_OFF_BITS;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;
  logic                  line_valid_q, line_valid_d;
  logic                  drop_pending_q, drop_pending_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  redir_hit;
  logic                  xfer;
  logic                  unused_entry_lsb;

  assign redir_pc         = {entry_pc[ADDR_WIDTH-1:2], 2'b00};
  assign redir_hit        = line_valid_q && (entry_pc[ADDR_WIDTH-1:LINE_OFF_BITS] == line_tag_q);
  assign unused_entry_lsb = ^entry_pc[1:0];

  // A redirect suppresses valid in the same cycle so decode never takes a stale word.
  assign instr_valid = (state_q == SERVE) && !entry_valid;
  assign xfer        = instr_valid && instr_ready;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign instr_pc = pc_q;

  fetch_word_select #(
    .LINE_BITS   (LINE_BITS),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_word_select (
    .line_i  (line_q),
    .idx_i   (word_idx(pc_q)),
    .instr_o (instr)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    line_tag_d     = line_tag_q;
    line_valid_d   = line_valid_q;
    drop_pending_d = drop_pending_q;
    line_d         = line_q;
    mem_addr_d     = mem_addr_q;

    unique case (state_q)
      IDLE: begin
        if (entry_valid) begin
          pc_d       = redir_pc;
          state_d    = REQ;
          mem_addr_d = line_addr(redir_pc);
        end
      end

      REQ: begin
        if (entry_valid) begin
          pc_d       = redir_pc;
          mem_addr_d = line_addr(redir_pc);
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (entry_valid) begin
          pc_d = redir_pc;
          if (mem_data_valid) begin
            state_d        = REQ;
            drop_pending_d = 1'b0;
            mem_addr_d     = line_addr(redir_pc);
          end else begin
            drop_pending_d = 1'b1;
          end
        end else if (mem_data_valid) begin
          if (drop_pending_q) begin
            state_d        = REQ;
            drop_pending_d = 1'b0;
            mem_addr_d     = line_addr(pc_q);
          end else begin
            state_d      = SERVE;
            line_d       = mem_data;
            line_tag_d   = pc_q[ADDR_WIDTH-1:LINE_OFF_BITS];
            line_valid_d = 1'b1;
          end
        end
      end

      SERVE: begin
        if (entry_valid) begin
          pc_d = redir_pc;
          if (!redir_hit) begin
            state_d    = REQ;
            mem_addr_d = line_addr(redir_pc);
          end
        end else if (xfer) begin
          pc_d = pc_q + ADDR_WIDTH'(4);
          if (word_idx(pc_q) == WORD_IDX_BITS'(WORDS_PER_LINE - 1)) begin
            state_d    = REQ;
            mem_addr_d = line_addr(pc_q + ADDR_WIDTH'(4));
          end
        end
      end

      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d == REQ) || (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      line_tag_q     <= '0;
      line_valid_q   <= 1'b0;
      drop_pending_q <= 1'b0;
      line_q         <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      line_tag_q     <= line_tag_d;
      line_valid_q   <= line_valid_d;
      drop_pending_q <= drop_pending_d;
      line_q         <= line_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
    end
  end

endmodule
